// File: rtl/fx_mac_pkg.sv
// Shared definitions for the fixed-point MAC sequencer slice.
//  - Sequencer state encoding.
//  - Operand width and window length defaults shared with the MAC.
//  - MAC idle-clear depth and the minimum legal inter-window gap it implies.
//  - clog2_min1: address width helper that never returns 0.
package fx_mac_pkg;

  localparam int unsigned FX_WIDTH      = 8;
  localparam int unsigned FX_K          = 9;
  localparam int unsigned MAC_CLR_DEPTH = 5;
  localparam int unsigned MIN_GAP_CYC   = MAC_CLR_DEPTH + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FEED,
    S_DRAIN,
    S_GAP,
    S_DONE
  } seq_state_t;

  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/fx_mac_seq_if.sv
// Bus bundle between the MAC sequencer, the weight/data memories, the MAC
// and the result buffer.
//  master (sequencer): drives w_addr, d_addr, rd_en, mac_vld, mac_win,
//                      mac_din, res_we, res_addr, res_data;
//                      receives w_rdata, d_rdata, mac_vld_o, mac_acc.
//  slave  (environment): the mirror image.
interface fx_mac_seq_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW_W  = 8,
  parameter int unsigned AW_D  = 4,
  parameter int unsigned AW_O  = 4
);
  logic [AW_W-1:0]  w_addr;
  logic [AW_D-1:0]  d_addr;
  logic             rd_en;
  logic [WIDTH-1:0] w_rdata;
  logic [WIDTH-1:0] d_rdata;
  logic             mac_vld;
  logic [WIDTH-1:0] mac_win;
  logic [WIDTH-1:0] mac_din;
  logic             mac_vld_o;
  logic [WIDTH-1:0] mac_acc;
  logic             res_we;
  logic [AW_O-1:0]  res_addr;
  logic [WIDTH-1:0] res_data;

  modport master (
    output w_addr, d_addr, rd_en, mac_vld, mac_win, mac_din,
           res_we, res_addr, res_data,
    input  w_rdata, d_rdata, mac_vld_o, mac_acc
  );

  modport slave (
    input  w_addr, d_addr, rd_en, mac_vld, mac_win, mac_din,
           res_we, res_addr, res_data,
    output w_rdata, d_rdata, mac_vld_o, mac_acc
  );
endinterface

// File: rtl/fx_mac_seq_cnt.sv
// Generic up-counter with synchronous load, count enable and terminal flag.
//  clk, rst    : clock, synchronous active-high reset (count -> 0)
//  i_load      : load i_load_val (priority over i_en)
//  i_en        : increment by one
//  i_load_val  : load value
//  i_tc_val    : terminal value compared against the current count
//  o_cnt       : current count
//  o_tc        : high while o_cnt == i_tc_val
module fx_mac_seq_cnt #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_en,
  input  logic [W-1:0] i_load_val,
  input  logic [W-1:0] i_tc_val,
  output logic [W-1:0] o_cnt,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst)         r_cnt <= '0;
    else if (i_load) r_cnt <= i_load_val;
    else if (i_en)   r_cnt <= r_cnt + W'(1);
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == i_tc_val);

endmodule

// File: rtl/fx_mac_seq.sv
// Sequencer for one fixed-point MAC unit. Per start pulse it runs NUM_OUT
// windows: K weight/data reads streamed into the MAC, wait for the MAC
// result, write it to the result buffer at index o, then idle GAP_CYC cycles
// so the MAC self-clears before the next window.
//  clk, rst : clock, synchronous active-high reset
//  start    : job request, honoured only in IDLE after the post-reset hold-off
//  busy     : job in progress (FEED/DRAIN/GAP)
//  done     : 1-cycle pulse once the job has finished
//  err      : sticky MAC-result watchdog error, cleared by start or rst
//  bus      : memory read port, MAC operand/result and result-buffer write
// Optional build macro FX_MAC_SEQ_TIMEOUT_EN: DRAIN gives up after TMO_CYC
// cycles without a MAC result, sets err and finishes the job without a write.
// Without it DRAIN waits indefinitely and err stays 0.
module fx_mac_seq
  import fx_mac_pkg::*;
#(
  parameter int unsigned WIDTH   = FX_WIDTH,
  parameter int unsigned K       = FX_K,
  parameter int unsigned NUM_OUT = 16,
  parameter int unsigned GAP_CYC = MIN_GAP_CYC,
  parameter int unsigned TMO_CYC = 32,
  parameter int unsigned AW_W    = clog2_min1(NUM_OUT * K),
  parameter int unsigned AW_D    = clog2_min1(K),
  parameter int unsigned AW_O    = clog2_min1(NUM_OUT)
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  output logic err,
  fx_mac_seq_if.master bus
);

  localparam int unsigned T_MAX = (GAP_CYC > TMO_CYC) ? GAP_CYC : TMO_CYC;
  localparam int unsigned TW    = clog2_min1(T_MAX + 1);

  seq_state_t r_state, w_state_nxt;

  logic [AW_D-1:0]  w_k;
  logic             w_k_tc, w_k_load, w_k_en;
  logic [AW_O-1:0]  w_o;
  logic             w_o_tc, w_o_load, w_o_en;
  logic [TW-1:0]    w_t, w_t_lim;
  logic             w_t_tc, w_t_load, w_t_en;

  logic             r_rst_wait;
  logic             r_mac_vld;
  logic             r_res_we;
  logic [AW_O-1:0]  r_res_addr;
  logic [WIDTH-1:0] r_res_data;
  logic [AW_W-1:0]  r_base;
  logic             r_err;

  logic             w_start_ok;
  logic             w_acc_take;
  logic             w_tmo;

  assign w_start_ok = (r_state == S_IDLE) && start && !r_rst_wait;
  assign w_acc_take = (r_state == S_DRAIN) && bus.mac_vld_o;

`ifdef FX_MAC_SEQ_TIMEOUT_EN
  assign w_tmo = (r_state == S_DRAIN) && !bus.mac_vld_o && w_t_tc;
`else
  assign w_tmo = 1'b0;
`endif

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_start_ok) w_state_nxt = S_FEED;
      S_FEED:  if (w_k_tc)     w_state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (w_acc_take)  w_state_nxt = w_o_tc ? S_DONE : S_GAP;
        else if (w_tmo)  w_state_nxt = S_DONE;
      end
      S_GAP:   if (w_t_tc)     w_state_nxt = S_FEED;
      S_DONE:                  w_state_nxt = S_IDLE;
      default:                 w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------- FSM outputs ----------------
  always_comb begin
    busy       = (r_state == S_FEED) || (r_state == S_DRAIN) || (r_state == S_GAP);
    done       = (r_state == S_DONE);
    bus.rd_en  = (r_state == S_FEED);
  end

  // ---------------- counter control ----------------
  // One timer serves three purposes: post-reset hold-off in IDLE, the
  // inter-window gap in GAP and (optionally) the result watchdog in DRAIN.
  always_comb begin
    w_k_load = (r_state == S_FEED) && w_k_tc;
    w_k_en   = (r_state == S_FEED);

    w_o_load = w_start_ok;
    w_o_en   = (r_state == S_GAP) && w_t_tc;

    w_t_load = ((r_state == S_FEED) && w_k_tc) || w_acc_take;
    w_t_en   = !w_t_tc &&
               (((r_state == S_IDLE) && r_rst_wait) || (r_state == S_GAP));
`ifdef FX_MAC_SEQ_TIMEOUT_EN
    if ((r_state == S_DRAIN) && !w_t_tc) w_t_en = 1'b1;
`endif
    w_t_lim  = (r_state == S_DRAIN) ? TW'(TMO_CYC - 1) : TW'(GAP_CYC - 1);
  end

  fx_mac_seq_cnt #(.W(AW_D)) u_cnt_k (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_k_load),
    .i_en       (w_k_en),
    .i_load_val ('0),
    .i_tc_val   (AW_D'(K - 1)),
    .o_cnt      (w_k),
    .o_tc       (w_k_tc)
  );

  fx_mac_seq_cnt #(.W(AW_O)) u_cnt_o (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_o_load),
    .i_en       (w_o_en),
    .i_load_val ('0),
    .i_tc_val   (AW_O'(NUM_OUT - 1)),
    .o_cnt      (w_o),
    .o_tc       (w_o_tc)
  );

  fx_mac_seq_cnt #(.W(TW)) u_cnt_t (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_t_load),
    .i_en       (w_t_en),
    .i_load_val ('0),
    .i_tc_val   (w_t_lim),
    .o_cnt      (w_t),
    .o_tc       (w_t_tc)
  );

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rst_wait <= 1'b1;
      r_mac_vld  <= 1'b0;
      r_res_we   <= 1'b0;
      r_res_addr <= '0;
      r_res_data <= '0;
      r_base     <= '0;
      r_err      <= 1'b0;
    end else begin
      r_mac_vld <= (r_state == S_FEED);
      r_res_we  <= w_acc_take;
      if (w_acc_take) begin
        r_res_addr <= w_o;
        r_res_data <= bus.mac_acc;
      end
      // Running window base replaces o*K.
      if (w_start_ok)                        r_base <= '0;
      else if ((r_state == S_GAP) && w_t_tc) r_base <= r_base + AW_W'(K);
      if ((r_state == S_IDLE) && r_rst_wait && w_t_tc) r_rst_wait <= 1'b0;
`ifdef FX_MAC_SEQ_TIMEOUT_EN
      if (w_start_ok) r_err <= 1'b0;
      else if (w_tmo) r_err <= 1'b1;
`else
      r_err <= 1'b0;
`endif
    end
  end

  assign err          = r_err;
  assign bus.w_addr   = r_base + AW_W'(w_k);
  assign bus.d_addr   = w_k;
  assign bus.mac_vld  = r_mac_vld;
  // Operands pass straight through while valid; forced to 0 otherwise so the
  // MAC-side outputs are clean during reset and idle.
  assign bus.mac_win  = r_mac_vld ? bus.w_rdata : '0;
  assign bus.mac_din  = r_mac_vld ? bus.d_rdata : '0;
  assign bus.res_we   = r_res_we;
  assign bus.res_addr = r_res_addr;
  assign bus.res_data = r_res_data;

  // w_t is only consumed through its terminal flag.
  logic w_unused;
  assign w_unused = ^w_t;

endmodule

// File: tb/tb_fx_mac_seq.sv
module tb_fx_mac_seq;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned K       = 9;
  localparam int unsigned NUM_OUT = 2;
  localparam int unsigned GAP_CYC = 6;
  localparam int unsigned TMO_CYC = 32;
  localparam int unsigned AW_W    = $clog2(NUM_OUT * K);
  localparam int unsigned AW_D    = $clog2(K);
  localparam int unsigned AW_O    = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  // Bench MAC needs 2 cycles after its last valid product to present a result;
  // the rd_en -> mac_vld register adds one more low cycle before the next window.
  localparam int unsigned MAC_LAT = 2;
  localparam int unsigned EXP_LOW = MAC_LAT + GAP_CYC + 1;

  logic clk = 1'b0;
  logic rst, start;
  logic busy, done, err;

  fx_mac_seq_if #(.WIDTH(WIDTH), .AW_W(AW_W), .AW_D(AW_D), .AW_O(AW_O)) bus ();

  fx_mac_seq #(
    .WIDTH(WIDTH), .K(K), .NUM_OUT(NUM_OUT), .GAP_CYC(GAP_CYC),
    .TMO_CYC(TMO_CYC), .AW_W(AW_W), .AW_D(AW_D), .AW_O(AW_O)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .busy (busy),
    .done (done),
    .err  (err),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // ---------------- memories (1-cycle read latency) ----------------
  logic signed [WIDTH-1:0] wmem [NUM_OUT*K];
  logic signed [WIDTH-1:0] dmem [K];

  initial begin
    bus.w_rdata = '0;
    bus.d_rdata = '0;
  end

  always @(posedge clk) begin
    if (bus.rd_en) begin
      bus.w_rdata <= wmem[bus.w_addr];
      bus.d_rdata <= dmem[bus.d_addr];
    end
  end

  // ---------------- behavioural MAC ----------------
  function automatic logic [WIDTH-1:0] sat_q44(input int a);
    int s;
    s = a >>> 4;
    if (s > 127)  return 8'h7F;
    if (s < -128) return 8'h80;
    return WIDTH'(s);
  endfunction

  int               mac_accum;
  logic             mac_prev;
  logic             mac_pulse;
  logic [WIDTH-1:0] mac_res;
  logic             withhold;
  logic             inj;

  always @(posedge clk) begin
    mac_pulse <= 1'b0;
    if (rst) begin
      mac_accum <= 0;
      mac_prev  <= 1'b0;
      mac_res   <= '0;
    end else begin
      mac_prev <= bus.mac_vld;
      if (bus.mac_vld)
        mac_accum <= mac_accum + int'($signed(bus.mac_win)) * int'($signed(bus.mac_din));
      else if (mac_prev) begin
        mac_pulse <= !withhold;
        mac_res   <= sat_q44(mac_accum);
        mac_accum <= 0;
      end
    end
  end

  assign bus.mac_vld_o = mac_pulse | inj;
  assign bus.mac_acc   = inj ? 8'h5A : mac_res;

  // ---------------- reference model / scoreboard ----------------
  typedef struct packed {
    logic [AW_O-1:0]  a;
    logic [WIDTH-1:0] d;
  } exp_t;

  exp_t q[$];
  int   exp_writes;
  logic exp_err;

  task automatic push_expected();
    for (int o = 0; o < int'(NUM_OUT); o++) begin
      int s;
      exp_t e;
      s = 0;
      for (int k = 0; k < int'(K); k++)
        s += int'(wmem[o*K + k]) * int'(dmem[k]);
      e.a = AW_O'(o);
      e.d = sat_q44(s);
      q.push_back(e);
    end
  endtask

  task automatic load_mem(input bit rnd);
    for (int i = 0; i < int'(NUM_OUT*K); i++) wmem[i] = rnd ? WIDTH'($urandom) : 8'h10;
    for (int i = 0; i < int'(K); i++)         dmem[i] = rnd ? WIDTH'($urandom) : 8'h20;
  endtask

  // ---------------- monitor ----------------
  int   mon_feed, mon_run, mon_low, mon_win, mon_wr;
  logic mon_prev;
  exp_t mon_e;

  always @(negedge clk) begin
    if (rst) begin
      mon_feed = 0; mon_run = 0; mon_low = 0; mon_win = 0; mon_wr = 0;
      mon_prev = 1'b0;
    end else begin
      if (bus.rd_en) begin
        check("w_addr", bus.w_addr, mon_feed);
        check("d_addr", bus.d_addr, mon_feed % K);
        mon_feed++;
      end
      if (bus.mac_vld) begin
        if (!mon_prev && mon_win > 0) check("vld_gap", mon_low, EXP_LOW);
        mon_run++;
        mon_low = 0;
      end else begin
        if (mon_prev) begin
          check("vld_len", mon_run, K);
          mon_run = 0;
          mon_win++;
        end
        mon_low++;
      end
      mon_prev = bus.mac_vld;
      if (bus.res_we) begin
        if (q.size() == 0) check("spurious_res_we", bus.res_we, 0);
        else begin
          mon_e = q.pop_front();
          check("res_addr", bus.res_addr, mon_e.a);
          check("res_data", bus.res_data, mon_e.d);
          mon_wr++;
        end
      end
      if (done) begin
        check("busy_at_done", busy, 0);
        check("writes_per_job", mon_wr, exp_writes);
        check("err_at_done", err, exp_err);
        check("pending_at_done", q.size(), 0);
        mon_feed = 0; mon_win = 0; mon_wr = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (!done && n < 400) begin
      tick();
      n++;
    end
    check({nm, "_done_seen"}, done, 1);
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_busy"},     busy, 0);
    check({nm, "_done"},     done, 0);
    check({nm, "_err"},      err, 0);
    check({nm, "_rd_en"},    bus.rd_en, 0);
    check({nm, "_mac_vld"},  bus.mac_vld, 0);
    check({nm, "_res_we"},   bus.res_we, 0);
    check({nm, "_w_addr"},   bus.w_addr, 0);
    check({nm, "_d_addr"},   bus.d_addr, 0);
    check({nm, "_res_addr"}, bus.res_addr, 0);
    check({nm, "_res_data"}, bus.res_data, 0);
    check({nm, "_mac_win"},  bus.mac_win, 0);
    check({nm, "_mac_din"},  bus.mac_din, 0);
  endtask

  task automatic holdoff_probe(input string nm);
    // start issued before the post-reset hold-off expires must be dropped
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check({nm, "_busy"},  busy, 0);
    check({nm, "_rd_en"}, bus.rd_en, 0);
    repeat (GAP_CYC + 2) tick();
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; inj = 1'b0; withhold = 1'b0;
    exp_writes = NUM_OUT; exp_err = 1'b0;
    load_mem(1'b0);
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    holdoff_probe("holdoff0");

    // 1/2: constant operands, window length, gaps and address sequence
    push_expected();
    start_job();
    wait_done("job1");
    tick();

    // 3: start during FEED and in the DONE cycle are ignored
    load_mem(1'b1);
    push_expected();
    start_job();
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("job3");
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_in_done_busy", busy, 0);
    tick();
    check("start_in_done_rd_en", bus.rd_en, 0);

    // 5: stray MAC result during GAP
    load_mem(1'b1);
    push_expected();
    start_job();
    n = 0;
    while (!bus.res_we && n < 200) begin tick(); n++; end
    check("job5_first_write_seen", bus.res_we, 1);
    inj = 1'b1;
    tick();
    inj = 1'b0;
    wait_done("job5");
    tick();

    // 4: reset in the middle of FEED
    load_mem(1'b1);
    push_expected();
    start_job();
    n = 0;
    while (!(bus.rd_en && bus.d_addr == 4) && n < 50) begin tick(); n++; end
    check("job4_reached_k4", bus.d_addr, 4);
    rst = 1'b1;
    tick();
    check_reset_outputs("midrst");
    q.delete();
    rst = 1'b0;
    holdoff_probe("holdoff1");
    load_mem(1'b1);
    push_expected();
    start_job();
    wait_done("job4b");
    tick();

`ifdef FX_MAC_SEQ_TIMEOUT_EN
    // 6: MAC result withheld -> watchdog
    withhold = 1'b1; exp_writes = 0; exp_err = 1'b1;
    start_job();
    begin
      int drain;
      bit fed;
      drain = 0; fed = 1'b0; n = 0;
      while (!done && n < 200) begin
        tick(); n++;
        if (done) break;
        if (bus.rd_en) fed = 1'b1;
        else if (fed) drain++;
      end
      check("tmo_done_seen", done, 1);
      check("tmo_drain_cycles", drain, TMO_CYC);
      check("tmo_err", err, 1);
    end
    tick();
    check("err_sticky", err, 1);
    withhold = 1'b0; exp_writes = NUM_OUT; exp_err = 1'b0;
    load_mem(1'b1);
    push_expected();
    start_job();
    check("err_cleared_by_start", err, 0);
    wait_done("job6b");
    tick();
`endif

    repeat (5) tick();
    check("final_pending", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
